gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

Sequential stimulus-and-check stage that sits directly upstream and downstream of a 2-input gate under test (`and_gate` and its siblings). It walks the four input combinations in the order 00, 01, 10, 11 on its `a`/`b` outputs and holds each one for a programmable number of cycles. It samples the gate output `y` at the end of each hold and reports the captured truth table, a per-row mismatch mask and a pass flag. It replaces hand-written delay-driven stimulus with a clocked, self-checking sequencer usable in simulation and on hardware.

## Interface
- `HOLD_CYCLES`, default 4: cycles each input combination is driven; legal range ≥ 1.
- `EXPECTED`, default 4'b1000: expected truth table, bit index = {a,b}; 4'b1000 is AND.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a run; sampled only in IDLE.
- `a`  output  1  gate input A, registered.
- `b`  output  1  gate input B, registered.
- `y`  input  1  gate output being checked.
- `busy`  output  1  high while combinations are being driven.
- `done`  output  1  one-cycle pulse at end of run.
- `result`  output  4  captured y per row, bit index = {a,b}.
- `fail_mask`  output  4  `result ^ EXPECTED`, valid with `pass`.
- `pass`  output  1  high when `result == EXPECTED` after a completed run.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE.** `a`=`b`=0 and `busy`=0. On `start`=1: go to RUN, `idx`=0, `hold_cnt`=0, clear `result`, `fail_mask` and `pass` to 0, and set `busy`=1.
- **RUN.**
  - Drive `{a,b}` = `idx` (2-bit).
  - `hold_cnt` increments each cycle.
  - At the edge where `hold_cnt == HOLD_CYCLES-1`:
    - `result[idx]` ← `y`.
    - `hold_cnt` ← 0.
    - If `idx`==3, go to DONE. Otherwise `idx` ← `idx`+1 and the new `{a,b}` appears on that same edge.
- **DONE.** Lasts exactly one cycle. `done`=1, `busy`=0, `a`=`b`=0. `pass` and `fail_mask` are registered from the final `result` on entry to DONE. Then go to IDLE.
- `result`, `fail_mask` and `pass` hold their values until the next accepted `start`.
- `start` is ignored in RUN and DONE. It is not queued.
- `y` is assumed settled by the last cycle of each hold. It is sampled once per row, and there is no glitch filtering.
- Reset (asynchronous, at any time, including mid-RUN): state=IDLE, `idx`=0, `hold_cnt`=0, and all outputs 0 (`a`, `b`, `busy`, `done`, `result`, `fail_mask`, `pass`). There is no partial-result retention.

## Timing
- Accepted `start` is at edge N. `{a,b}`=00 is visible after edge N.
- Row k is driven from edge N+k·H to edge N+(k+1)·H, with H=`HOLD_CYCLES`. `y` for row k is sampled at edge N+(k+1)·H.
- `done`, `pass` and `fail_mask` are valid after edge N+4H. `done` drops after edge N+4H+1.
- Earliest next accepted `start` is sampled at edge N+4H+2 (IDLE).
- `hold_cnt` width is max(1, $clog2(HOLD_CYCLES)). With H=1 the counter never increments, and each row lasts one cycle.
- All outputs are registered, and there is no combinational path from `y` or `start` to any output.

## Structure
- Shared package `gate_check_pkg` contains:
  - the state enum (IDLE, RUN, DONE);
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001, `TT_XNOR`=4'b1001.
- One sub-module, `hold_counter`: parameterised by `HOLD_CYCLES`, with inputs `clk`, `rst_n`, `clear`, `en` and output `last` (high when count == `HOLD_CYCLES-1`).
- The FSM, row index and result capture live in the top module.

## Test plan
- `and_gate` attached, H=4, `start` pulsed at cycle 0 → `{a,b}` = 00, 01, 10, 11 for 4 cycles each; `done` at cycle 16; `result`=4'b1000, `fail_mask`=0, `pass`=1.
- `y` tied to 0, `EXPECTED`=`TT_AND` → `result`=4'b0000, `fail_mask`=4'b1000, `pass`=0, `done` still at cycle 16.
- `start` re-pulsed at cycles 3 and 16 during a run → ignored; single `done` at cycle 16, and row timing unchanged.
- `rst_n` low at cycle 6 mid-RUN → all outputs 0 immediately, with no clock needed. After release, `start` gives a complete fresh run with correct `result`.
- H=1 with `y` driven as `a|b` and `EXPECTED`=`TT_OR` → `done` 4 cycles after `start`, `pass`=1. Back-to-back `start` in the first IDLE cycle after DONE is accepted, and `result` clears to 0 on that edge.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the 2-input gate checker.
// Truth-table bit index is {a,b}.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_table_checker_hold_counter.sv
// Per-row hold counter: counts 0..HOLD_CYCLES-1 while enabled and wraps.
// 'last' flags the final cycle of a hold.
module hold_counter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

  // With a single-cycle hold the count is pinned at 0, so every cycle is last.
  assign last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Clocked stimulus-and-check sequencer for a 2-input gate: walks {a,b} through
// 00,01,10,11, samples y at the end of each hold and reports the truth table.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [3:0]  EXPECTED    = TT_AND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] fail_mask,
  output logic       pass
);

  state_t     r_state;
  logic [1:0] r_idx;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_result;
  logic [3:0] r_fail_mask;
  logic       r_pass;

  logic       w_last;
  logic       w_run;
  logic [1:0] w_idx_next;
  logic [3:0] w_result_next;

  assign w_run      = (r_state == RUN);
  assign w_idx_next = r_idx + 2'd1;

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(!w_run),
    .en   (w_run),
    .last (w_last)
  );

  // Final verdict must include the row sampled on the same edge that enters DONE.
  always_comb begin
    w_result_next        = r_result;
    w_result_next[r_idx] = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_state     <= RUN;
            r_idx       <= '0;
            r_result    <= '0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (w_last) begin
            r_result <= w_result_next;
            if (r_idx == 2'd3) begin
              r_state     <= DONE;
              r_idx       <= '0;
              r_a         <= 1'b0;
              r_b         <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_fail_mask <= w_result_next ^ EXPECTED;
              r_pass      <= (w_result_next == EXPECTED);
            end else begin
              r_idx        <= w_idx_next;
              {r_a, r_b}   <= w_idx_next;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign fail_mask = r_fail_mask;
  assign pass      = r_pass;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: an AND-checking instance (H=4) and an OR-checking instance (H=1).
module tb_gate_truth_table_checker;
  import gate_check_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start4 = 1'b0;
  logic start1 = 1'b0;
  logic zero_y = 1'b0;

  logic a4, b4, y4, busy4, done4, pass4;
  logic [3:0] res4, fm4;
  logic a1, b1, y1, busy1, done1, pass1;
  logic [3:0] res1, fm1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign y4 = zero_y ? 1'b0 : (a4 & b4);
  assign y1 = a1 | b1;

  gate_truth_table_checker #(
    .HOLD_CYCLES(4),
    .EXPECTED   (TT_AND)
  ) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .y        (y4),
    .busy     (busy4),
    .done     (done4),
    .result   (res4),
    .fail_mask(fm4),
    .pass     (pass4)
  );

  gate_truth_table_checker #(
    .HOLD_CYCLES(1),
    .EXPECTED   (TT_OR)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .a        (a1),
    .b        (b1),
    .y        (y1),
    .busy     (busy1),
    .done     (done1),
    .result   (res1),
    .fail_mask(fm1),
    .pass     (pass1)
  );

  typedef struct {
    logic       zero_y;
    logic       repulse;
    logic [3:0] exp_result;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } run_vec_t;

  run_vec_t vecs[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full H=4 run on dut4; c counts edges after the accepting edge N.
  task automatic run4(input run_vec_t v, input int id);
    logic [1:0] exp_ab;
    zero_y = v.zero_y;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) begin
        start4 = v.repulse && (c == 3 || c == 16);
        tick;
        start4 = 1'b0;
      end
      exp_ab = (c < 16) ? 2'(c / 4) : 2'b00;
      chk($sformatf("run%0d ctrl c=%0d", id, c), {12'h0, a4, b4, busy4, done4},
          {12'h0, exp_ab, (c < 16), (c == 16)});
      if (c == 0)
        chk($sformatf("run%0d cleared", id), {7'h0, res4, fm4, pass4}, 16'h0);
      if (c >= 16)
        chk($sformatf("run%0d verdict c=%0d", id, c), {7'h0, res4, fm4, pass4},
            {7'h0, v.exp_result, v.exp_fail, v.exp_pass});
    end
  endtask

  initial begin
    vecs[0] = '{zero_y: 1'b0, repulse: 1'b0, exp_result: 4'b1000, exp_fail: 4'b0000, exp_pass: 1'b1};
    vecs[1] = '{zero_y: 1'b1, repulse: 1'b0, exp_result: 4'b0000, exp_fail: 4'b1000, exp_pass: 1'b0};
    vecs[2] = '{zero_y: 1'b0, repulse: 1'b1, exp_result: 4'b1000, exp_fail: 4'b0000, exp_pass: 1'b1};
    vecs[3] = '{zero_y: 1'b1, repulse: 1'b1, exp_result: 4'b0000, exp_fail: 4'b1000, exp_pass: 1'b0};

    #12;
    chk("reset dut4", {3'h0, a4, b4, busy4, done4, res4, fm4, pass4}, 16'h0);
    chk("reset dut1", {3'h0, a1, b1, busy1, done1, res1, fm1, pass1}, 16'h0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle no start", {13'h0, a4, b4, busy4}, 16'h0);

    for (int i = 0; i < 4; i++) run4(vecs[i], i);

    // Asynchronous reset mid-run, six edges after acceptance (row 01 driven).
    zero_y = 1'b0;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    repeat (6) tick;
    chk("pre-reset ctrl", {13'h0, a4, b4, busy4}, {13'h0, 3'b011});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset", {3'h0, a4, b4, busy4, done4, res4, fm4, pass4}, 16'h0);
    tick;
    chk("reset held", {3'h0, a4, b4, busy4, done4, res4, fm4, pass4}, 16'h0);
    rst_n = 1'b1;
    tick;
    run4(vecs[0], 4);

    // H=1 OR check, then back-to-back start in first IDLE cycle after DONE.
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick;
      chk($sformatf("h1 ctrl c=%0d", c), {12'h0, a1, b1, busy1, done1},
          {12'h0, (c < 4) ? 2'(c) : 2'b00, (c < 4), (c == 4)});
      if (c >= 4)
        chk($sformatf("h1 verdict c=%0d", c), {7'h0, res1, fm1, pass1},
            {7'h0, 4'b1110, 4'b0000, 1'b1});
    end
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("h1 b2b accept", {6'h0, a1, b1, busy1, done1, res1, fm1, pass1},
        {6'h0, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0});
    repeat (4) tick;
    chk("h1 b2b verdict", {6'h0, a1, b1, busy1, done1, res1, fm1, pass1},
        {6'h0, 2'b00, 1'b0, 1'b1, 4'b1110, 4'b0000, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
